hpi_bus_sequencer: RTL and testbench

HPI_BUS_SEQUENCER -- requirements
Module: hpi_bus_sequencer

---
 rtl/hpi_bus_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_hpi_bus_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_bus_sequencer.sv
// Purpose : turns SoC PIO request levels into timed HPI chip cycles (setup / strobe / hold).
// Latency : SETUP_CYC+STROBE_CYC+HOLD_CYC cycles from busy rise to busy fall; busy rises the cycle after a request edge.
// Backpr. : no queueing; request edges seen while busy are dropped, and a level still held at completion does not retrigger.
//
// Ports:
//   clk_clk, reset_reset_n           - clock, async active-low reset
//   otg_hpi_cs/r/w_export            - SoC PIO active-low chip-select / read / write levels
//   otg_hpi_address_export [1:0]     - SoC register address
//   otg_hpi_data_out_port  [15:0]    - SoC write data
//   otg_hpi_data_in_port   [15:0]    - registered read data back to the SoC
//   busy                             - access in progress
//   otg_addr, otg_cs_n/rd_n/wr_n     - registered chip-side address and strobes
//   otg_data               [15:0]    - bidirectional chip data bus
module hpi_bus_sequencer #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        otg_hpi_cs_export,
  input  logic [1:0]  otg_hpi_address_export,
  input  logic [15:0] otg_hpi_data_out_port,
  input  logic        otg_hpi_r_export,
  input  logic        otg_hpi_w_export,
  output logic [15:0] otg_hpi_data_in_port,
  output logic        busy,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  inout  wire  [15:0] otg_data
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
    $error("hpi_bus_sequencer: phase lengths must be in 1..15");
  end

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        req_rd, req_wr;
  logic        req_rd_hist_q, req_wr_hist_q;
  logic        start;

  logic        dir_wr_q, dir_wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;

  // With cs, r and w all low neither level is true, so the conflict case never starts an access.
  assign req_rd = !otg_hpi_cs_export && !otg_hpi_r_export &&  otg_hpi_w_export;
  assign req_wr = !otg_hpi_cs_export && !otg_hpi_w_export &&  otg_hpi_r_export;
  // The history registers track levels every cycle, busy or not, so a level held
  // through an access has no edge left when IDLE is re-entered.
  assign start  = (req_rd && !req_rd_hist_q) || (req_wr && !req_wr_hist_q);

  // ---------------- state register ----------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------- output / datapath next values ----------------
  // Pin registers are loaded from the *next* state so each pin changes on the same
  // edge as the FSM; this keeps busy, cs_n and the strobes cycle-aligned.
  always_comb begin
    dir_wr_d = dir_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (state_q == S_IDLE && start) begin
      dir_wr_d = req_wr;
      addr_d   = otg_hpi_address_export;
      if (req_wr) begin
        wdata_d = otg_hpi_data_out_port;
      end
    end
    // Sample the chip bus at the close of the last strobe cycle.
    if (state_q == S_STROBE && cnt_q == 4'd0 && !dir_wr_q) begin
      rdata_d = otg_data;
    end

    busy_d = (state_d != S_IDLE);
    cs_n_d = (state_d == S_IDLE);
    rd_n_d = !(state_d == S_STROBE && !dir_wr_d);
    wr_n_d = !(state_d == S_STROBE &&  dir_wr_d);
    oe_d   = (state_d != S_IDLE) && dir_wr_d;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      req_rd_hist_q <= 1'b0;
      req_wr_hist_q <= 1'b0;
      dir_wr_q      <= 1'b0;
      addr_q        <= 2'd0;
      wdata_q       <= 16'h0000;
      rdata_q       <= 16'h0000;
      busy_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      oe_q          <= 1'b0;
    end else begin
      req_rd_hist_q <= req_rd;
      req_wr_hist_q <= req_wr;
      dir_wr_q      <= dir_wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      cs_n_q        <= cs_n_d;
      rd_n_q        <= rd_n_d;
      wr_n_q        <= wr_n_d;
      oe_q          <= oe_d;
    end
  end

  assign otg_hpi_data_in_port = rdata_q;
  assign busy                 = busy_q;
  assign otg_addr             = addr_q;
  assign otg_cs_n             = cs_n_q;
  assign otg_rd_n             = rd_n_q;
  assign otg_wr_n             = wr_n_q;
  assign otg_data             = oe_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Purpose : directed bench for hpi_bus_sequencer (default timing plus a 1/1/1 instance).
// Latency : cycle c=1 is the first cycle after the request edge is clocked in.
// Backpr. : none; inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_hpi_bus_sequencer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n;
  logic        cs, r, w;
  logic [1:0]  addr;
  logic [15:0] dout;
  logic [15:0] din;
  logic        busy;
  logic [1:0]  oaddr;
  logic        cs_n, rd_n, wr_n;
  wire  [15:0] bus;
  logic [15:0] chip_val;

  // Chip model: drives the bus only while selected and read-strobed.
  assign bus = (!cs_n && !rd_n) ? chip_val : 16'hzzzz;

  hpi_bus_sequencer dut (
    .clk_clk                (clk),
    .reset_reset_n          (rst_n),
    .otg_hpi_cs_export      (cs),
    .otg_hpi_address_export (addr),
    .otg_hpi_data_out_port  (dout),
    .otg_hpi_r_export       (r),
    .otg_hpi_w_export       (w),
    .otg_hpi_data_in_port   (din),
    .busy                   (busy),
    .otg_addr               (oaddr),
    .otg_cs_n               (cs_n),
    .otg_rd_n               (rd_n),
    .otg_wr_n               (wr_n),
    .otg_data               (bus)
  );

  logic        p_cs, p_r, p_w;
  logic [1:0]  p_addr;
  logic [15:0] p_dout;
  logic [15:0] p_din;
  logic        p_busy;
  logic [1:0]  p_oaddr;
  logic        p_cs_n, p_rd_n, p_wr_n;
  wire  [15:0] p_bus;
  logic [15:0] p_chip_val;

  assign p_bus = (!p_cs_n && !p_rd_n) ? p_chip_val : 16'hzzzz;

  hpi_bus_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk_clk                (clk),
    .reset_reset_n          (rst_n),
    .otg_hpi_cs_export      (p_cs),
    .otg_hpi_address_export (p_addr),
    .otg_hpi_data_out_port  (p_dout),
    .otg_hpi_r_export       (p_r),
    .otg_hpi_w_export       (p_w),
    .otg_hpi_data_in_port   (p_din),
    .busy                   (p_busy),
    .otg_addr               (p_oaddr),
    .otg_cs_n               (p_cs_n),
    .otg_rd_n               (p_rd_n),
    .otg_wr_n               (p_wr_n),
    .otg_data               (p_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // An undriven net reads as all-z in a four-state simulator and as zero in a two-state one.
  function automatic logic bus_released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  int wr_low_cnt, busy_cnt, rd_low_cnt, wr_pulses;
  logic wr_n_prev;

  initial begin
    rst_n = 1'b0;
    cs = 1'b1; r = 1'b1; w = 1'b1; addr = 2'd0; dout = 16'h0000; chip_val = 16'hBEEF;
    p_cs = 1'b1; p_r = 1'b1; p_w = 1'b1; p_addr = 2'd0; p_dout = 16'h0000; p_chip_val = 16'hC0DE;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_rd_n", 32'(rd_n), 32'd1);
    check("rst_wr_n", 32'(wr_n), 32'd1);
    check("rst_addr", 32'(oaddr), 32'd0);
    check("rst_din", 32'(din), 32'h0000);
    check("rst_bus_released", 32'(bus_released(bus)), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- write: addr 2, data 0x1234; SoC inputs change mid-access ----
    cs = 1'b0; addr = 2'd2; dout = 16'h1234; w = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("wr_busy_c%0d", c), 32'(busy), 32'((c <= 8) ? 1 : 0));
      check($sformatf("wr_cs_n_c%0d", c), 32'(cs_n), 32'((c <= 8) ? 0 : 1));
      check($sformatf("wr_wr_n_c%0d", c), 32'(wr_n), 32'((c >= 3 && c <= 6) ? 0 : 1));
      check($sformatf("wr_rd_n_c%0d", c), 32'(rd_n), 32'd1);
      if (c <= 8) begin
        check($sformatf("wr_addr_c%0d", c), 32'(oaddr), 32'd2);
        check($sformatf("wr_bus_c%0d", c), 32'(bus), 32'h1234);
      end else begin
        check($sformatf("wr_bus_released_c%0d", c), 32'(bus_released(bus)), 32'd1);
      end
      if (c == 1) begin
        addr = 2'd0; dout = 16'hFFFF;
      end
    end
    w = 1'b1; cs = 1'b1;
    @(negedge clk);

    // ---- read: addr 1, chip returns 0xBEEF ----
    cs = 1'b0; addr = 2'd1; r = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("rd_busy_c%0d", c), 32'(busy), 32'((c <= 8) ? 1 : 0));
      check($sformatf("rd_rd_n_c%0d", c), 32'(rd_n), 32'((c >= 3 && c <= 6) ? 0 : 1));
      check($sformatf("rd_wr_n_c%0d", c), 32'(wr_n), 32'd1);
      check($sformatf("rd_din_c%0d", c), 32'(din), (c >= 7) ? 32'hBEEF : 32'h0000);
      if (c >= 3 && c <= 6)
        check($sformatf("rd_bus_c%0d", c), 32'(bus), 32'hBEEF);
      else
        check($sformatf("rd_bus_released_c%0d", c), 32'(bus_released(bus)), 32'd1);
      if (c <= 8) check($sformatf("rd_addr_c%0d", c), 32'(oaddr), 32'd1);
    end
    r = 1'b1; cs = 1'b1;
    @(negedge clk);

    // ---- conflict: cs, r, w all low, then release w -> read ----
    chip_val = 16'h5A5A;
    cs = 1'b0; r = 1'b0; w = 1'b0;
    busy_cnt = 0; rd_low_cnt = 0; wr_low_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      rd_low_cnt += int'(!rd_n);
      wr_low_cnt += int'(!wr_n);
      check($sformatf("cf_cs_n_c%0d", c), 32'(cs_n), 32'd1);
    end
    check("cf_busy_cycles", 32'(busy_cnt), 32'd0);
    check("cf_strobe_cycles", 32'(rd_low_cnt + wr_low_cnt), 32'd0);
    w = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("cf_rd_busy_c%0d", c), 32'(busy), 32'((c <= 8) ? 1 : 0));
      check($sformatf("cf_rd_rd_n_c%0d", c), 32'(rd_n), 32'((c >= 3 && c <= 6) ? 0 : 1));
    end
    check("cf_rd_din", 32'(din), 32'h5A5A);
    r = 1'b1; cs = 1'b1;
    @(negedge clk);

    // ---- overlap: second write edge at cycle 4, then w held past the end ----
    cs = 1'b0; addr = 2'd3; dout = 16'hA55A; w = 1'b0;
    busy_cnt = 0; wr_low_cnt = 0; wr_pulses = 0; wr_n_prev = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      wr_low_cnt += int'(!wr_n);
      if (wr_n_prev && !wr_n) wr_pulses++;
      wr_n_prev = wr_n;
      if (c == 2) w = 1'b1;
      if (c == 4) w = 1'b0;
    end
    check("ov_busy_cycles", 32'(busy_cnt), 32'd8);
    check("ov_wr_low_cycles", 32'(wr_low_cnt), 32'd4);
    check("ov_wr_pulses", 32'(wr_pulses), 32'd1);
    check("ov_idle_busy", 32'(busy), 32'd0);
    w = 1'b1; cs = 1'b1;
    @(negedge clk);

    // ---- reset during strobe cycle 2 of a write ----
    check("rs_din_before", 32'(din), 32'h5A5A);
    cs = 1'b0; addr = 2'd2; dout = 16'h1357; w = 1'b0;
    repeat (4) @(negedge clk);
    check("rs_wr_n_strobe2", 32'(wr_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rs_async_busy", 32'(busy), 32'd0);
    check("rs_async_wr_n", 32'(wr_n), 32'd1);
    @(negedge clk);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_cs_n", 32'(cs_n), 32'd1);
    check("rs_rd_n", 32'(rd_n), 32'd1);
    check("rs_wr_n", 32'(wr_n), 32'd1);
    check("rs_addr", 32'(oaddr), 32'd0);
    check("rs_bus_released", 32'(bus_released(bus)), 32'd1);
    check("rs_din", 32'(din), 32'h0000);
    // Release with the write level still held: counts as a fresh edge.
    rst_n = 1'b1;
    busy_cnt = 0; wr_low_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) check("rs_restart_busy", 32'(busy), 32'd1);
      busy_cnt += int'(busy);
      wr_low_cnt += int'(!wr_n);
    end
    check("rs_restart_busy_cycles", 32'(busy_cnt), 32'd8);
    check("rs_restart_wr_low", 32'(wr_low_cnt), 32'd4);
    w = 1'b1; cs = 1'b1;
    @(negedge clk);

    // ---- 1/1/1 timing: read completes in 3 cycles ----
    p_cs = 1'b0; p_addr = 2'd2; p_r = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("fast_busy_c%0d", c), 32'(p_busy), 32'((c <= 3) ? 1 : 0));
      check($sformatf("fast_rd_n_c%0d", c), 32'(p_rd_n), 32'((c == 2) ? 0 : 1));
      check($sformatf("fast_din_c%0d", c), 32'(p_din), (c >= 3) ? 32'hC0DE : 32'h0000);
      if (c <= 3) check($sformatf("fast_addr_c%0d", c), 32'(p_oaddr), 32'd2);
    end
    p_r = 1'b1; p_cs = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
